// File: rtl/sync_down_divider.sv
// Loadable down-counting clock divider with terminal-count pulse and toggling divided output.
// Define SYNC_DOWN_DIVIDER_AUTORELOAD_EN for a free-running divider; the default build is one-shot.
//
// state | meaning
// IDLE  | no count in progress, q_o = 0, waiting for a load
// RUN   | counting down, en_i was high on the last edge
// PAUSE | count held, en_i was low on the last edge
module sync_down_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             abort_i,
  input  logic             load_valid_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             load_ready_o,
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o,
  output logic             div_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] next_reload;
  logic             load_acc;

  always_comb begin
`ifdef SYNC_DOWN_DIVIDER_AUTORELOAD_EN
    load_ready_o = !abort_i;
`else
    load_ready_o = !abort_i && (state == IDLE);
`endif
    load_acc    = load_valid_i && load_ready_o;
    // A load landing on the terminal-count edge must win over the old reload value.
    next_reload = load_acc ? load_val_i : reload;
    busy_o      = (state != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      q_o    <= '0;
      tc_o   <= 1'b0;
      div_o  <= 1'b0;
      reload <= '0;
    end else if (abort_i) begin
      state <= IDLE;
      q_o   <= '0;
      tc_o  <= 1'b0;
    end else begin
      tc_o <= 1'b0;
      case (state)
        IDLE: begin
          if (load_acc) begin
            if (load_val_i != '0) begin
              reload <= load_val_i;
              q_o    <= load_val_i;
              state  <= RUN;
            end else begin
              tc_o <= 1'b1;
            end
          end
        end
        RUN, PAUSE: begin
          reload <= next_reload;
          if (!en_i) begin
            state <= PAUSE;
          end else if (q_o > ONE) begin
            q_o   <= q_o - ONE;
            state <= RUN;
          end else if (q_o == ONE) begin
            tc_o  <= 1'b1;
            div_o <= ~div_o;
`ifdef SYNC_DOWN_DIVIDER_AUTORELOAD_EN
            // A zero reload cannot be counted down, so it ends the run instead.
            if (next_reload != '0) begin
              q_o   <= next_reload;
              state <= RUN;
            end else begin
              q_o   <= '0;
              state <= IDLE;
            end
`else
            q_o   <= '0;
            state <= IDLE;
`endif
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_down_divider.sv
// Self-checking bench for sync_down_divider: directed scenarios plus randomized traffic
// compared every cycle against a cycle-count model of the divider.
module tb_sync_down_divider;

  localparam int W = 8;
`ifdef SYNC_DOWN_DIVIDER_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         en_i;
  logic         abort_i;
  logic         load_valid_i;
  logic [W-1:0] load_val_i;
  logic         load_ready_o;
  logic [W-1:0] q_o;
  logic         tc_o;
  logic         div_o;
  logic         busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  sync_down_divider #(.WIDTH(W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .abort_i      (abort_i),
    .load_valid_i (load_valid_i),
    .load_val_i   (load_val_i),
    .load_ready_o (load_ready_o),
    .q_o          (q_o),
    .tc_o         (tc_o),
    .div_o        (div_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Model: "active" means a count is in progress; cnt is the remaining count.
  bit m_active = 1'b0;
  int m_cnt    = 0;
  int m_rel    = 0;
  bit m_tc     = 1'b0;
  bit m_div    = 1'b0;
  bit m_rdy;
  bit m_acc;
  int m_nrel;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_active = 1'b0;
      m_cnt    = 0;
      m_rel    = 0;
      m_tc     = 1'b0;
      m_div    = 1'b0;
    end else begin
      m_rdy = !abort_i && (AUTO || !m_active);
      m_acc = load_valid_i && m_rdy;
      m_tc  = 1'b0;
      if (abort_i) begin
        m_active = 1'b0;
        m_cnt    = 0;
      end else if (!m_active) begin
        if (m_acc) begin
          if (int'(load_val_i) == 0) begin
            m_tc = 1'b1;
          end else begin
            m_rel    = int'(load_val_i);
            m_cnt    = int'(load_val_i);
            m_active = 1'b1;
          end
        end
      end else begin
        m_nrel = m_acc ? int'(load_val_i) : m_rel;
        m_rel  = m_nrel;
        if (en_i) begin
          if (m_cnt > 1) begin
            m_cnt = m_cnt - 1;
          end else begin
            m_tc  = 1'b1;
            m_div = !m_div;
            if (AUTO && m_nrel != 0) begin
              m_cnt = m_nrel;
            end else begin
              m_cnt    = 0;
              m_active = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare against the model at the falling edge, then advance past the next rising edge.
  task automatic tick();
    @(negedge clk_i);
    check("model_q", int'(q_o), m_cnt);
    check("model_tc", int'(tc_o), int'(m_tc));
    check("model_div", int'(div_o), int'(m_div));
    check("model_busy", int'(busy_o), int'(m_active));
    check("model_ready", int'(load_ready_o), int'(!abort_i && (AUTO || !m_active)));
    @(posedge clk_i);
    #2;
  endtask

  int pq[10];

  initial begin
    rst_i        = 1'b1;
    en_i         = 1'b0;
    abort_i      = 1'b0;
    load_valid_i = 1'b0;
    load_val_i   = '0;
    repeat (2) @(posedge clk_i);
    #2;
    rst_i = 1'b0;

    check("rst_q", int'(q_o), 0);
    check("rst_tc", int'(tc_o), 0);
    check("rst_div", int'(div_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_ready", int'(load_ready_o), 1);

    // Load 3 with enable held.
    load_val_i = 8'd3; load_valid_i = 1'b1; en_i = 1'b1;
    tick();
    load_valid_i = 1'b0;
    check("a_q3", int'(q_o), 3);
    check("a_busy", int'(busy_o), 1);
    check("a_ready_busy", int'(load_ready_o), AUTO ? 1 : 0);
    tick();
    check("a_q2", int'(q_o), 2);
    tick();
    check("a_q1", int'(q_o), 1);
    check("a_tc_early", int'(tc_o), 0);
    tick();
    check("a_q_tc", int'(q_o), AUTO ? 3 : 0);
    check("a_tc", int'(tc_o), 1);
    check("a_busy_after", int'(busy_o), AUTO ? 1 : 0);
    check("a_div", int'(div_o), 1);
    tick();
    check("a_tc_single", int'(tc_o), 0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_q", int'(q_o), 0);
    check("abort_busy", int'(busy_o), 0);
    check("abort_div_hold", int'(div_o), 1);

    // Reset while q_o = 3 of a count from 5.
    load_val_i = 8'd5; load_valid_i = 1'b1; en_i = 1'b1;
    tick();
    load_valid_i = 1'b0;
    tick();
    tick();
    check("mr_q3", int'(q_o), 3);
    rst_i = 1'b1;
    #1;
    check("mr_q_now", int'(q_o), 0);
    check("mr_busy_now", int'(busy_o), 0);
    check("mr_div_now", int'(div_o), 0);
    check("mr_tc_now", int'(tc_o), 0);
    tick();
    check("mr_tc_held", int'(tc_o), 0);
    rst_i = 1'b0;
    tick();
    check("mr_no_resume_q", int'(q_o), 0);
    check("mr_no_resume_busy", int'(busy_o), 0);

    // Pause: N=6, enable dropped for 3 cycles at q_o=4.
    pq = '{6, 5, 4, 4, 4, 4, 3, 2, 1, 0};
    for (int i = 0; i < 10; i++) begin
      load_valid_i = (i == 0);
      load_val_i   = 8'd6;
      en_i         = !(i >= 3 && i <= 5);
      tick();
      check("p_q", int'(q_o), (i == 9) ? (AUTO ? 6 : 0) : pq[i]);
      check("p_tc", int'(tc_o), (i == 9) ? 1 : 0);
      if (i >= 3 && i <= 5) check("p_busy", int'(busy_o), 1);
    end
    load_valid_i = 1'b0;
    en_i = 1'b1;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;

`ifdef SYNC_DOWN_DIVIDER_AUTORELOAD_EN
    // Free-running N=4: tc every 4 cycles, div period 8.
    load_val_i = 8'd4; load_valid_i = 1'b1; en_i = 1'b1;
    tick();
    load_valid_i = 1'b0;
    check("ar_q4", int'(q_o), 4);
    for (int i = 1; i <= 24; i++) begin
      tick();
      check("ar_tc", int'(tc_o), (i % 4 == 0) ? 1 : 0);
      check("ar_q", int'(q_o), (i % 4 == 0) ? 4 : 4 - (i % 4));
      check("ar_div", int'(div_o), 1 ^ ((i / 4) % 2));
    end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;

    // New load on the terminal-count edge of N=5 replaces the reload.
    load_val_i = 8'd5; load_valid_i = 1'b1;
    tick();
    load_valid_i = 1'b0;
    repeat (4) tick();
    check("rl_q1", int'(q_o), 1);
    load_val_i = 8'd2; load_valid_i = 1'b1;
    tick();
    load_valid_i = 1'b0;
    check("rl_q2", int'(q_o), 2);
    check("rl_tc", int'(tc_o), 1);
    tick();
    check("rl_q1b", int'(q_o), 1);
    tick();
    check("rl_tc2", int'(tc_o), 1);
    check("rl_q2b", int'(q_o), 2);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
`endif

    // Zero load: single tc pulse, stays idle.
    load_val_i = 8'd0; load_valid_i = 1'b1;
    tick();
    load_valid_i = 1'b0;
    check("z_tc", int'(tc_o), 1);
    check("z_q", int'(q_o), 0);
    check("z_busy", int'(busy_o), 0);
    tick();
    check("z_tc_single", int'(tc_o), 0);
    check("z_busy2", int'(busy_o), 0);

    // Abort together with a load in IDLE.
    abort_i = 1'b1; load_valid_i = 1'b1; load_val_i = 8'd7;
    #1;
    check("al_ready", int'(load_ready_o), 0);
    tick();
    check("al_q", int'(q_o), 0);
    check("al_busy", int'(busy_o), 0);
    check("al_tc", int'(tc_o), 0);
    abort_i = 1'b0; load_valid_i = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      abort_i      = ($urandom_range(0, 31) == 0);
      load_valid_i = ($urandom_range(0, 3) == 0);
      load_val_i   = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 255))
                                                 : W'($urandom_range(0, 7));
      en_i         = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) begin
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
      end else begin
        tick();
      end
    end
    abort_i = 1'b0; load_valid_i = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_down_divider.md
SYNC_DOWN_DIVIDER -- requirements
Module: sync_down_divider

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the counter and load-value width in bits (legal range 2..16).
REQ-002 The module SHALL have port clk_i, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port en_i, input, 1 bit: count enable.
REQ-005 The module SHALL have port abort_i, input, 1 bit: synchronous abort to IDLE.
REQ-006 The module SHALL have port load_valid_i, input, 1 bit: load request.
REQ-007 The module SHALL have port load_val_i, input, WIDTH bits: divide value N.
REQ-008 The module SHALL have port load_ready_o, output, 1 bit: load accept; it is combinational.
REQ-009 The module SHALL have port q_o, output, WIDTH bits: current count, registered.
REQ-010 The module SHALL have port tc_o, output, 1 bit: terminal-count pulse, registered.
REQ-011 The module SHALL have port div_o, output, 1 bit: divided output, registered.
REQ-012 The module SHALL have port busy_o, output, 1 bit: high when state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and PAUSE, plus an internal WIDTH-bit reload register.
REQ-014 A load SHALL be accepted on a rising edge where load_valid_i=1 and load_ready_o=1.
REQ-015 In IDLE, load_ready_o SHALL be equal to !abort_i.
REQ-016 An accepted load in IDLE with N!=0 SHALL set reload=N and q_o=N and move the FSM to RUN, all on the next edge.
REQ-017 An accepted load in IDLE with N=0 SHALL pulse tc_o for 1 cycle, leave q_o=0, and keep the FSM in IDLE.
REQ-018 In RUN or PAUSE, the counter SHALL decrement on every edge where en_i=1; the next state is RUN if en_i=1 and PAUSE if en_i=0.
REQ-019 In RUN or PAUSE with en_i=0, q_o SHALL hold its value.
REQ-020 A decrement from q_o>1 SHALL give q_o-1 with tc_o=0.
REQ-021 A decrement from q_o=1 is the terminal count: on the same edge, tc_o=1 for exactly one cycle and div_o toggles; the next value of q_o is set by REQ-030/031.
REQ-022 q_o SHALL never wrap from 0 to all-ones, and it never decrements while in IDLE.
REQ-023 abort_i=1 in any state SHALL give state IDLE, q_o=0 and tc_o=0 on the next edge, and div_o SHALL hold its value.
REQ-024 abort_i SHALL have priority over load, terminal count and en_i.
REQ-025 If a load is accepted on the same edge as a terminal count, the new N SHALL replace the reload value that terminal count would otherwise use.
REQ-026 When en_i is held high, tc_o SHALL have a period of N cycles and div_o a period of 2N cycles, with 50% duty.

Reset
REQ-027 While rst_i=1, the block SHALL immediately force state=IDLE, q_o=0, tc_o=0, div_o=0, busy_o=0 and reload=0, independent of clk_i.
REQ-028 A reset asserted mid-count SHALL discard the count in progress with no tc_o pulse.
REQ-029 Counting SHALL resume only after rst_i is released and a new load is accepted.

Configuration
REQ-030 With macro SYNC_DOWN_DIVIDER_AUTORELOAD_EN defined:
- at terminal count, q_o=reload and the FSM stays in RUN (free-running divider);
- load_ready_o=!abort_i in all states;
- a load accepted in RUN or PAUSE updates the reload register only and takes effect at the next terminal count.
REQ-031 Without SYNC_DOWN_DIVIDER_AUTORELOAD_EN (one-shot):
- at terminal count, q_o=0 and the FSM returns to IDLE;
- load_ready_o=0 whenever busy_o=1.

Verification
REQ-032 The bench SHALL cover reset mid-count: WIDTH=8, load N=5, en_i=1, rst_i pulsed while q_o=3 -> q_o=0, busy_o=0 and div_o=0 immediately, with no tc_o pulse.
REQ-033 The bench SHALL cover the one-shot build: load N=3 with en_i=1 -> q_o sequence 3,2,1,0; tc_o high for 1 cycle; busy_o low afterwards; load_ready_o=0 during the count.
REQ-034 The bench SHALL cover the autoreload build: load N=4 with en_i=1 for 24 cycles -> tc_o every 4 cycles and div_o period 8 cycles; q_o cycles 4,3,2,1,4,...
REQ-035 The bench SHALL cover pause: load N=6, drop en_i for 3 cycles at q_o=4 -> state PAUSE, q_o holds 4, then resumes 3,2,1; tc_o is delayed by exactly 3 cycles.
REQ-036 The bench SHALL cover abort with simultaneous load: in IDLE, abort_i=1 and load_valid_i=1 with N=7 -> load_ready_o=0, no load, q_o stays 0.
REQ-037 The bench SHALL cover zero load and reload-on-terminal-count:
- load N=0 -> single tc_o pulse, busy_o stays 0;
- in the autoreload build, load N=2 on the terminal-count edge of N=5 -> next q_o=2.
